muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS pipeline.
- Sits beside the EX stage and consumes forwarded rs/rt operands for MULT, MULTU, DIV and DIVU.
- Holds the HI/LO architectural registers and serves MFHI/MFLO, MTHI and MTLO.
- Drives `busy` so the hazard unit stalls the pipeline on a HI/LO access or a new start while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width. Counter width is clog2(WIDTH).

Ports:
- clk1  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin operation `op`; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- flush  in  1  abort the in-flight operation (exception or CP0 redirect).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight; the pipeline must stall HI/LO readers and new starts.
- done  out  1  one-cycle pulse when HI/LO are updated by a completed operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, cnt=0.
  - hi=0, lo=0, busy=0, done=0.
  - Internal accumulators are cleared.
- States:
  - IDLE -> CALC on start&~flush.
  - CALC runs WIDTH iterations, cnt 0..WIDTH-1; CALC -> FIN when cnt==WIDTH-1.
  - FIN -> IDLE.
- Timing, with the start-sampling edge as E0:
  - Iterations occur at E1..E32.
  - FIN is occupied after E32.
  - At E33 hi/lo are written and done=1 for exactly one cycle.
  - busy=1 from after E0 until E33, i.e. 33 cycles. busy=0 in IDLE and is combinational from state.
- Operand capture at E0:
  - Signed ops (MULT, DIV) capture absolute values of a and b.
  - Result sign is recorded: sign(a)^sign(b) for the product/quotient, sign(a) for the remainder.
  - Unsigned ops capture raw values.
- Multiply:
  - Shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - In FIN, negate the product if the sign flag is set.
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring, one quotient bit per cycle.
  - In FIN, apply sign correction: quotient by xor-sign, remainder by dividend sign.
  - LO = quotient, HI = remainder.
- Divide by zero (b==0), signed or unsigned: LO=0xFFFFFFFF, HI=a (raw operand), full latency, no sign correction.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy: ignored. The stall logic is expected never to issue it.
- flush:
  - In CALC or FIN, return to IDLE next edge.
  - HI/LO unchanged, no done pulse.
  - flush and start in the same IDLE cycle: flush wins and no operation starts.
- flush and reset together: reset dominates.
- hi_we/lo_we:
  - Honoured in IDLE only; wdata is written at the next edge. Writes while busy are ignored.
  - hi_we and lo_we both high: both registers get wdata.
  - start with hi_we/lo_we in the same IDLE cycle: the write takes effect and the operation later overwrites at completion.
- Completion write has priority over any strobe (strobes are ignored in FIN anyway).
- hi/lo are direct register outputs with no bypass. A reader must wait until busy=0.

Optional Feature:
- Macro: MULDIV_FASTMUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle signed/unsigned native multiplier: IDLE -> FIN directly.
  - hi/lo are written at E1, done=1 after E1, busy=1 for one cycle.
  - Divide is unchanged.
- Undefined: all ops are iterative with 33-cycle busy, as above.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, done pulse 1 cycle.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU a=100 b=7 -> LO=14, HI=2.
- DIVU a=0x1234 b=0 -> LO=0xFFFFFFFF, HI=0x1234.
- MTHI 0xA5A5A5A5 idle -> HI=0xA5A5A5A5.
- DIV started then flush at cycle 10 -> busy=0 next cycle, HI/LO unchanged, no done.
- Assert reset at cycle 5 of MULT -> hi=lo=0, busy=0 immediately (asynchronous, before the next edge).

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide) for the MIPS EX stage.
// Optional macro MULDIV_FASTMUL_EN: MULT/MULTU use a native single-cycle multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_e;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
    abs_val = (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     araw_q, araw_d;
  logic                 sign_q, sign_d;
  logic                 rsign_q, rsign_d;
  logic                 is_div_q, is_div_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 sgn_op_s;
  logic [WIDTH-1:0]     a_abs_s;
  logic [WIDTH-1:0]     b_abs_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_trial_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;
`ifdef MULDIV_FASTMUL_EN
  logic [2*WIDTH-1:0]   fast_prod_s;
`endif

  // Per-iteration datapath and final sign correction
  always_comb begin
    sgn_op_s    = ~op[0];
    a_abs_s     = abs_val(a, sgn_op_s);
    b_abs_s     = abs_val(b, sgn_op_s);
    // acc = {partial product, remaining multiplier bits}: add then shift right
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // acc = {remainder, remaining dividend bits / quotient bits}
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opb_q};
    prod_s      = sign_q ? -acc_q : acc_q;
    quo_s       = sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s       = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_FASTMUL_EN
    fast_prod_s = {{WIDTH{a[WIDTH-1] & sgn_op_s}}, a} * {{WIDTH{b[WIDTH-1] & sgn_op_s}}, b};
`endif
  end

  // Next-state, operand capture, iteration and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    araw_d   = araw_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
        if (start && !flush) begin
          state_d  = CALC;
          cnt_d    = {CW{1'b0}};
          is_div_d = op[1];
          sign_d   = sgn_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
          rsign_d  = sgn_op_s & a[WIDTH-1];
          dz_d     = op[1] & (b == {WIDTH{1'b0}});
          araw_d   = a;
          opb_d    = op[1] ? b_abs_s : a_abs_s;
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_abs_s : b_abs_s)};
`ifdef MULDIV_FASTMUL_EN
          if (!op[1]) begin
            state_d = FIN;
            sign_d  = 1'b0;
            acc_d   = fast_prod_s;
          end else begin
            state_d = CALC;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          if (is_div_q) begin
            acc_d = {(div_trial_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~div_trial_s[WIDTH]};
          end else begin
            acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = FIN;
            cnt_d   = {CW{1'b0}};
          end else begin
            cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = araw_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      araw_q   <= {WIDTH{1'b0}};
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      araw_q   <= araw_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
